fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Upstream stage of the 8-bit unified memory: owns its single address/din/we port and its combinational dout.
- Prefetches instruction bytes from the PC into a small FIFO for the decoder.
- Arbitrates the same port for execute-stage loads and stores; data access has priority.
- Handles PC redirects from branch resolution.

Parameters:
- ADDR_W, 8, memory address width (PC width)
- DATA_W, 8, byte width
- FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >=2)
- RESET_PC, 8'h00, PC value after reset

Ports:
- clk  in  1  single clock, posedge
- rst_n  in  1  reset; asynchronous, active-low
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_we  out  1  memory write enable (committed at posedge)
- mem_dout  in  DATA_W  memory read data (combinational from mem_addr)
- fetch_en  in  1  allow instruction fetch
- instr_data  out  DATA_W  FIFO head byte
- instr_pc  out  ADDR_W  address of head byte
- instr_valid  out  1  head valid
- instr_ready  in  1  decoder accepts head
- redir_valid  in  1  PC redirect request
- redir_addr  in  ADDR_W  redirect target
- dreq_valid  in  1  data access request
- dreq_we  in  1  1 = store, 0 = load
- dreq_addr  in  ADDR_W  data address
- dreq_wdata  in  DATA_W  store data
- dreq_ready  out  1  data access granted this cycle
- drsp_valid  out  1  load data valid (one cycle)
- drsp_data  out  DATA_W  load data

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO empty; instr_valid=0; drsp_valid=0.
  - drsp_data=0; mem_we=0; mem_addr=pc; mem_din=0.
  - Reset mid-access aborts the access; no write occurs while rst_n=0.
- Port owner each cycle, combinational:
  - DATA if dreq_valid. dreq_ready=1.
    - mem_addr=dreq_addr; mem_we=dreq_we; mem_din=dreq_wdata.
  - Else FETCH if fetch_en and can_push.
    - mem_addr=pc; mem_we=0.
  - Else IDLE: mem_addr=pc; mem_we=0.
  - mem_din=0 whenever mem_we=0.
- can_push = (count<FIFO_DEPTH) or (instr_valid and instr_ready). Push-on-full with a same-cycle pop is legal.
- Load: drsp_data<=mem_dout and drsp_valid<=1 at the granting posedge, so the response arrives 1 cycle after grant. drsp_valid is otherwise 0. A store produces no response.
- Fetch: at posedge, push {mem_dout, pc} and set pc<=pc+1. PC wraps 8'hFF->8'h00.
- Pop: on instr_valid and instr_ready. instr_valid=(count!=0). Outputs come from registered storage, with no combinational path from mem_dout.
- Redirect (redir_valid), highest priority for PC/FIFO:
  - At posedge: FIFO flushed, any same-cycle push discarded, a same-cycle pop ignored.
  - pc<=redir_addr. instr_valid=0 the following cycle.
  - A simultaneous data access still completes.
- Continuous dreq_valid starves fetch; no fairness guarantee (execute stalls are bounded by the ISA).
- count is never >FIFO_DEPTH and never <0. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: FETCH_SMC_SNOOP_EN.
- Defined: a granted store whose dreq_addr equals the address of any valid FIFO entry causes, at that posedge:
  - FIFO flush;
  - pc<=oldest matching entry's address if the head matches, otherwise the head address (refetch from the head).
  - redir_valid in the same cycle overrides this.
- Undefined: stores never touch the FIFO. Stale bytes may be delivered. Address compare logic is absent.

Decomposition:
- Package cpu_pkg: ADDR_W, DATA_W, RESET_PC, and the owner enum typedef (OWN_IDLE, OWN_FETCH, OWN_DATA).
- Sub-module fetch_fifo: parameterised synchronous FIFO storing {addr, byte}.
  - Ports: push, pop, flush, full, empty, head outputs.
  - Exposes the entry-address array for the snoop feature.

Test Plan:
- Reset, memory 00:21,01:25,02:71,03:30, fetch_en=1, instr_ready=1 -> instr_data 21,25,71,30 with instr_pc 00..03 on consecutive cycles from cycle 2.
- instr_ready=0 -> exactly 4 fetches then mem_addr holds 04, instr_valid stays 1. Raise instr_ready -> a pop and push occur in the same cycle, count stays 4.
- dreq load addr FB (mem FB=AA) while fetching -> dreq_ready=1 that cycle, pc unchanged, drsp_valid=1 / drsp_data=AA next cycle.
- dreq store addr FB data 55 -> mem_we=1, mem_addr=FB, mem_din=55 one cycle. A later load returns 55.
- redir_valid to 40 with FIFO holding 3 bytes -> next cycle instr_valid=0, then instr_pc=40. The PC wrap test from FE gives instr_pc FE, FF, 00.
- FETCH_SMC_SNOOP_EN: FIFO holds addr 02..05, store to 03 -> flush, refetch from 02 with the new byte at 03. Without the macro -> the old byte at 03 is delivered.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, reset PC and memory-port owner encoding for the fetch stage.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {address, byte} pairs with single-cycle flush.
// FETCH_SMC_SNOOP_EN exports entry addresses and valid bits for store snooping.
module fetch_fifo #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [AW-1:0]    push_addr_i,
  input  logic [DW-1:0]    push_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW-1:0]    head_addr_o,
`ifdef FETCH_SMC_SNOOP_EN
  output logic [AW-1:0]    entry_addr_o [DEPTH],
  output logic [DEPTH-1:0] entry_valid_o,
`endif
  output logic [DW-1:0]    head_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // A push on a full buffer is only issued alongside a pop, so the slot being overwritten is the departing head.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

`ifdef FETCH_SMC_SNOOP_EN
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (pop_i)  valid_d[rd_ptr_q] = 1'b0;
    if (push_i) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid_q <= '0;
    else if (flush_i) valid_q <= '0;
    else              valid_q <= valid_d;
  end

  assign entry_addr_o  = addr_q;
  assign entry_valid_o = valid_q;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage owning the unified memory port: instruction prefetch, data load/store arbitration, PC redirect.
// FETCH_SMC_SNOOP_EN enables flush-and-refetch when a store hits a prefetched address.
module fetch_unit #(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                DATA_W     = cpu_pkg::DATA_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
  input  logic              dreq_valid,
  input  logic              dreq_we,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [DATA_W-1:0] dreq_wdata,
  output logic              dreq_ready,
  output logic              drsp_valid,
  output logic [DATA_W-1:0] drsp_data
);

  import cpu_pkg::*;

  owner_e            owner;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              drsp_valid_q;
  logic [DATA_W-1:0] drsp_data_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              can_push;
  logic              flush;
  logic              fifo_push;
  logic              fifo_pop;
  logic              load_grant;
  logic              snoop_hit;

  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign can_push    = !fifo_full || pop;

  // Owner is forced idle during reset so an in-flight store cannot write memory.
  always_comb begin
    owner = OWN_IDLE;
    if (!rst_n)                    owner = OWN_IDLE;
    else if (dreq_valid)           owner = OWN_DATA;
    else if (fetch_en && can_push) owner = OWN_FETCH;
  end

  assign dreq_ready = (owner == OWN_DATA);
  assign mem_we     = (owner == OWN_DATA) && dreq_we;
  assign mem_addr   = (owner == OWN_DATA) ? dreq_addr : pc_q;
  assign mem_din    = mem_we ? dreq_wdata : '0;
  assign load_grant = (owner == OWN_DATA) && !dreq_we;

`ifdef FETCH_SMC_SNOOP_EN
  logic [ADDR_W-1:0]     entry_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entry_valid;

  always_comb begin
    snoop_hit = 1'b0;
    if (mem_we) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (entry_valid[i] && (entry_addr[i] == dreq_addr)) snoop_hit = 1'b1;
      end
    end
  end
`else
  assign snoop_hit = 1'b0;
`endif

  assign flush     = redir_valid || snoop_hit;
  assign fifo_push = (owner == OWN_FETCH) && !flush;
  assign fifo_pop  = pop && !flush;

  // A snoop hit always restarts at the head: the oldest match is either the head itself or younger than it.
  always_comb begin
    pc_d = pc_q;
    if (redir_valid)             pc_d = redir_addr;
    else if (snoop_hit)          pc_d = head_addr;
    else if (owner == OWN_FETCH) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      drsp_valid_q <= 1'b0;
      drsp_data_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      drsp_valid_q <= load_grant;
      if (load_grant) drsp_data_q <= mem_dout;
    end
  end

  assign drsp_valid = drsp_valid_q;
  assign drsp_data  = drsp_data_q;
  assign instr_data = head_data;
  assign instr_pc   = head_addr;

  fetch_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (fifo_push),
    .pop_i         (fifo_pop),
    .flush_i       (flush),
    .push_addr_i   (pc_q),
    .push_data_i   (mem_dout),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_addr_o   (head_addr),
`ifdef FETCH_SMC_SNOOP_EN
    .entry_addr_o  (entry_addr),
    .entry_valid_o (entry_valid),
`endif
    .head_data_o   (head_data)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 256-byte memory; expectations adapt to FETCH_SMC_SNOOP_EN.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;
  logic       fetch_en = 1'b0;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       redir_valid = 1'b0;
  logic [7:0] redir_addr = 8'h00;
  logic       dreq_valid = 1'b0;
  logic       dreq_we = 1'b0;
  logic [7:0] dreq_addr = 8'h00;
  logic [7:0] dreq_wdata = 8'h00;
  logic       dreq_ready;
  logic       drsp_valid;
  logic [7:0] drsp_data;

  logic [7:0] mem [256];
  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout),
    .fetch_en    (fetch_en),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr),
    .dreq_valid  (dreq_valid),
    .dreq_we     (dreq_we),
    .dreq_addr   (dreq_addr),
    .dreq_wdata  (dreq_wdata),
    .dreq_ready  (dreq_ready),
    .drsp_valid  (drsp_valid),
    .drsp_data   (drsp_data)
  );

  // Memory commits the write presented before the edge, one step after it so the DUT samples old data.
  task automatic tick();
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    #1;
    we = mem_we;
    a  = mem_addr;
    d  = mem_din;
    @(posedge clk);
    #1;
    if (we) mem[a] = d;
  endtask

  task automatic do_reset();
    fetch_en = 0; instr_ready = 0; redir_valid = 0; dreq_valid = 0; dreq_we = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    mem[8'h10] = 8'h11;
    rst_n = 0;
    dreq_valid = 1; dreq_we = 1; dreq_addr = 8'h10; dreq_wdata = 8'h99;
    tick();
    tick();
    #1;
    nCompared++; if (mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_we: got %h expected 0", mem_we); end
    nCompared++; if (mem_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_addr: got %h expected 00", mem_addr); end
    nCompared++; if (mem_din !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_din: got %h expected 00", mem_din); end
    nCompared++; if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ivalid: got %h expected 0", instr_valid); end
    nCompared++; if (drsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_dvalid: got %h expected 0", drsp_valid); end
    nCompared++; if (drsp_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_ddata: got %h expected 00", drsp_data); end
    nCompared++; if (mem[8'h10] !== 8'h11) begin nMismatched++; $display("[TB] FAIL reset_nowrite: got %h expected 11", mem[8'h10]); end
    dreq_valid = 0; dreq_we = 0;
    rst_n = 1;
  endtask

  task automatic test_fetch();
    logic [7:0] expData [4];
    expData = '{8'h21, 8'h25, 8'h71, 8'h30};
    do_reset();
    fetch_en = 1; instr_ready = 1;
    #1;
    nCompared++; if (mem_addr !== 8'h00) begin nMismatched++; $display("[TB] FAIL fetch_first_addr: got %h expected 00", mem_addr); end
    nCompared++; if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL fetch_empty: got %h expected 0", instr_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      nCompared++; if (instr_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL fetch_valid[%0d]: got %h expected 1", i, instr_valid); end
      nCompared++; if (instr_data !== expData[i]) begin nMismatched++; $display("[TB] FAIL fetch_data[%0d]: got %h expected %h", i, instr_data, expData[i]); end
      nCompared++; if (instr_pc !== 8'(i)) begin nMismatched++; $display("[TB] FAIL fetch_pc[%0d]: got %h expected %h", i, instr_pc, 8'(i)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1; instr_ready = 0;
    for (int i = 0; i < 6; i++) tick();
    nCompared++; if (mem_addr !== 8'h04) begin nMismatched++; $display("[TB] FAIL bp_stall_addr: got %h expected 04", mem_addr); end
    nCompared++; if (instr_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_valid: got %h expected 1", instr_valid); end
    nCompared++; if (instr_data !== 8'h21 || instr_pc !== 8'h00) begin nMismatched++; $display("[TB] FAIL bp_head: got %h@%h expected 21@00", instr_data, instr_pc); end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    #1;
    nCompared++; if (instr_pc !== 8'h01 || instr_data !== 8'h25) begin nMismatched++; $display("[TB] FAIL bp_pop_head: got %h@%h expected 25@01", instr_data, instr_pc); end
    nCompared++; if (mem_addr !== 8'h05) begin nMismatched++; $display("[TB] FAIL bp_push_addr: got %h expected 05", mem_addr); end
    tick();
    nCompared++; if (mem_addr !== 8'h05) begin nMismatched++; $display("[TB] FAIL bp_still_full: got %h expected 05", mem_addr); end
  endtask

  task automatic test_data_access();
    do_reset();
    mem[8'hFB] = 8'hAA;
    fetch_en = 1; instr_ready = 1;
    tick();
    tick();
    dreq_valid = 1; dreq_we = 0; dreq_addr = 8'hFB;
    #1;
    nCompared++; if (dreq_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_ready: got %h expected 1", dreq_ready); end
    nCompared++; if (mem_addr !== 8'hFB || mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_port: got %h/%h expected FB/0", mem_addr, mem_we); end
    tick();
    dreq_valid = 0;
    #1;
    nCompared++; if (drsp_valid !== 1'b1 || drsp_data !== 8'hAA) begin nMismatched++; $display("[TB] FAIL load_rsp: got %h/%h expected 1/AA", drsp_valid, drsp_data); end
    nCompared++; if (mem_addr !== 8'h02) begin nMismatched++; $display("[TB] FAIL load_pc_hold: got %h expected 02", mem_addr); end
    nCompared++; if (dreq_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_ready: got %h expected 0", dreq_ready); end
    tick();
    nCompared++; if (drsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_rsp_pulse: got %h expected 0", drsp_valid); end
    dreq_valid = 1; dreq_we = 1; dreq_addr = 8'hFB; dreq_wdata = 8'h55;
    #1;
    nCompared++; if (mem_we !== 1'b1 || mem_addr !== 8'hFB || mem_din !== 8'h55) begin nMismatched++; $display("[TB] FAIL store_port: got %h/%h/%h expected 1/FB/55", mem_we, mem_addr, mem_din); end
    tick();
    dreq_valid = 0; dreq_we = 0;
    #1;
    nCompared++; if (mem_we !== 1'b0 || mem_din !== 8'h00) begin nMismatched++; $display("[TB] FAIL store_release: got %h/%h expected 0/00", mem_we, mem_din); end
    nCompared++; if (drsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL store_norsp: got %h expected 0", drsp_valid); end
    dreq_valid = 1; dreq_we = 0; dreq_addr = 8'hFB;
    tick();
    dreq_valid = 0;
    nCompared++; if (drsp_valid !== 1'b1 || drsp_data !== 8'h55) begin nMismatched++; $display("[TB] FAIL store_readback: got %h/%h expected 1/55", drsp_valid, drsp_data); end
  endtask

  task automatic test_redirect();
    do_reset();
    mem[8'h40] = 8'h9C;
    mem[8'h80] = 8'h00;
    fetch_en = 1; instr_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    redir_valid = 1; redir_addr = 8'h40;
    dreq_valid = 1; dreq_we = 1; dreq_addr = 8'h80; dreq_wdata = 8'h3C;
    tick();
    redir_valid = 0; dreq_valid = 0; dreq_we = 0;
    #1;
    nCompared++; if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL redir_flush: got %h expected 0", instr_valid); end
    nCompared++; if (mem_addr !== 8'h40) begin nMismatched++; $display("[TB] FAIL redir_pc: got %h expected 40", mem_addr); end
    nCompared++; if (mem[8'h80] !== 8'h3C) begin nMismatched++; $display("[TB] FAIL redir_store: got %h expected 3C", mem[8'h80]); end
    tick();
    nCompared++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40 || instr_data !== 8'h9C) begin nMismatched++; $display("[TB] FAIL redir_head: got %h %h@%h expected 1 9C@40", instr_valid, instr_data, instr_pc); end
  endtask

  task automatic test_wrap();
    logic [7:0] expPc [3];
    logic [7:0] expData [3];
    expPc   = '{8'hFE, 8'hFF, 8'h00};
    expData = '{8'hE0, 8'hF1, 8'h21};
    mem[8'hFE] = 8'hE0; mem[8'hFF] = 8'hF1; mem[8'h00] = 8'h21;
    do_reset();
    fetch_en = 1; instr_ready = 1;
    redir_valid = 1; redir_addr = 8'hFE;
    tick();
    redir_valid = 0;
    #1;
    nCompared++; if (instr_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_discard: got %h expected 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++; if (instr_valid !== 1'b1 || instr_pc !== expPc[i] || instr_data !== expData[i]) begin nMismatched++; $display("[TB] FAIL wrap[%0d]: got %h %h@%h expected 1 %h@%h", i, instr_valid, instr_data, instr_pc, expData[i], expPc[i]); end
    end
  endtask

  task automatic test_snoop();
    logic [7:0] exp03;
`ifdef FETCH_SMC_SNOOP_EN
    exp03 = 8'hE7;
`else
    exp03 = 8'h30;
`endif
    mem[8'h02] = 8'h71; mem[8'h03] = 8'h30; mem[8'h04] = 8'h44; mem[8'h05] = 8'h5D;
    do_reset();
    fetch_en = 1; instr_ready = 0;
    redir_valid = 1; redir_addr = 8'h02;
    tick();
    redir_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    nCompared++; if (mem_addr !== 8'h06 || instr_pc !== 8'h02) begin nMismatched++; $display("[TB] FAIL snoop_fill: got %h/%h expected 06/02", mem_addr, instr_pc); end
    dreq_valid = 1; dreq_we = 1; dreq_addr = 8'h03; dreq_wdata = 8'hE7;
    tick();
    dreq_valid = 0; dreq_we = 0; instr_ready = 1;
    #1;
`ifdef FETCH_SMC_SNOOP_EN
    nCompared++; if (instr_valid !== 1'b0 || mem_addr !== 8'h02) begin nMismatched++; $display("[TB] FAIL snoop_flush: got %h/%h expected 0/02", instr_valid, mem_addr); end
    tick();
`else
    nCompared++; if (instr_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL snoop_keep: got %h expected 1", instr_valid); end
`endif
    nCompared++; if (instr_pc !== 8'h02 || instr_data !== 8'h71) begin nMismatched++; $display("[TB] FAIL snoop_head02: got %h@%h expected 71@02", instr_data, instr_pc); end
    tick();
    nCompared++; if (instr_pc !== 8'h03 || instr_data !== exp03) begin nMismatched++; $display("[TB] FAIL snoop_head03: got %h@%h expected %h@03", instr_data, instr_pc, exp03); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[8'h00] = 8'h21; mem[8'h01] = 8'h25; mem[8'h02] = 8'h71; mem[8'h03] = 8'h30;
    test_reset();
    test_fetch();
    test_backpressure();
    test_data_access();
    test_redirect();
    test_wrap();
    test_snoop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
